perf_monitor: RTL and testbench

Hardware performance monitor placed downstream of the pipeline top. It consumes the pipeline's writeback, stall, flush and mispredict strobes and counts cycles, retired instructions, stalls, flushes and mispredictions over one program run. At end of run it computes CPI in unsigned fixed point with a sequential restoring divider. This replaces bench-side CPI bookkeeping with synthesizable counters that the FPGA top can read out.

---
 rtl/perf_monitor.sv | 191 +++++++++++++++++++
 tb/tb_perf_monitor.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/perf_monitor.sv
// Pipeline performance monitor: event counters over one program run, then a
// restoring divide that produces CPI in unsigned Q(CNT_W-FRAC_W).FRAC_W.
module perf_monitor #(
   parameter int          CNT_W     = 32,
   parameter int          FRAC_W    = 8,
   parameter logic [31:0] END_VALUE = 32'h90
) (
   input  logic             clk_i,
   input  logic             reset_ni,
   input  logic             start_i,
   input  logic             stop_i,
   input  logic             wb_valid_i,
   input  logic [31:0]      wb_data_i,
   input  logic             stall_i,
   input  logic             flush_i,
   input  logic             mispredict_i,
   input  logic [2:0]       sel_i,
   output logic [CNT_W-1:0] rd_data_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [CNT_W-1:0] cpi_o,
   output logic             cpi_valid_o
);

   localparam int QW = CNT_W + FRAC_W;
   localparam int BW = $clog2(QW + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DIV,
      S_DONE
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cycles_q, cycles_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic [CNT_W-1:0] stalls_q, stalls_d;
   logic [CNT_W-1:0] flushes_q, flushes_d;
   logic [CNT_W-1:0] mispred_q, mispred_d;
   logic [CNT_W-1:0] cpi_q, cpi_d;
   logic [CNT_W-1:0] rd_data_q, rd_data_d;
   logic [QW-1:0]    dividend_q, dividend_d;
   logic [QW-1:0]    quot_q, quot_d;
   logic [CNT_W:0]   rem_q, rem_d;
   logic [BW-1:0]    bitcnt_q, bitcnt_d;

   logic             endRun;
   logic [CNT_W:0]   remShift;
   logic [CNT_W:0]   divisorExt;
   logic             remGeq;
   logic [CNT_W:0]   remNext;
   logic [QW-1:0]    quotNext;
   logic             quotOverflow;

   function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] c,
                                               input logic en);
      return (en && (c != '1)) ? c + CNT_W'(1) : c;
   endfunction

   assign endRun = stop_i | (wb_valid_i & (wb_data_i == END_VALUE));

   // One restoring step: the remainder carries one extra bit so the shifted
   // value can reach up to twice the divisor without losing the MSB.
   assign remShift     = {rem_q[CNT_W-1:0], dividend_q[QW-1]};
   assign divisorExt   = {1'b0, retired_q};
   assign remGeq       = (remShift >= divisorExt);
   assign remNext      = remGeq ? (remShift - divisorExt) : remShift;
   assign quotNext     = {quot_q[QW-2:0], remGeq};
   assign quotOverflow = |quotNext[QW-1:CNT_W];

   always_comb begin
      state_d    = state_q;
      cycles_d   = cycles_q;
      retired_d  = retired_q;
      stalls_d   = stalls_q;
      flushes_d  = flushes_q;
      mispred_d  = mispred_q;
      cpi_d      = cpi_q;
      dividend_d = dividend_q;
      quot_d     = quot_q;
      rem_d      = rem_q;
      bitcnt_d   = bitcnt_q;

      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               state_d   = S_RUN;
               cycles_d  = '0;
               retired_d = '0;
               stalls_d  = '0;
               flushes_d = '0;
               mispred_d = '0;
               cpi_d     = '0;
            end
         end

         S_RUN: begin
            if (start_i) begin
               cycles_d  = '0;
               retired_d = '0;
               stalls_d  = '0;
               flushes_d = '0;
               mispred_d = '0;
            end else begin
               cycles_d  = satInc(cycles_q, 1'b1);
               retired_d = satInc(retired_q, wb_valid_i);
               stalls_d  = satInc(stalls_q, stall_i);
               flushes_d = satInc(flushes_q, flush_i);
               mispred_d = satInc(mispred_q, mispredict_i);
               // The end cycle itself is counted, so load the incremented value.
               if (endRun) begin
                  state_d    = S_DIV;
                  dividend_d = {satInc(cycles_q, 1'b1), {FRAC_W{1'b0}}};
                  quot_d     = '0;
                  rem_d      = '0;
                  bitcnt_d   = '0;
               end
            end
         end

         S_DIV: begin
            if (retired_q == '0) begin
               state_d = S_DONE;
               cpi_d   = '1;
            end else begin
               rem_d      = remNext;
               quot_d     = quotNext;
               dividend_d = {dividend_q[QW-2:0], 1'b0};
               bitcnt_d   = bitcnt_q + BW'(1);
               if (bitcnt_q == BW'(QW - 1)) begin
                  state_d = S_DONE;
                  cpi_d   = quotOverflow ? '1 : quotNext[CNT_W-1:0];
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      rd_data_d = '0;
      case (sel_i)
         3'd0:    rd_data_d = cycles_q;
         3'd1:    rd_data_d = retired_q;
         3'd2:    rd_data_d = stalls_q;
         3'd3:    rd_data_d = flushes_q;
         3'd4:    rd_data_d = mispred_q;
         3'd5:    rd_data_d = cpi_q;
         default: rd_data_d = '0;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q    <= S_IDLE;
         cycles_q   <= '0;
         retired_q  <= '0;
         stalls_q   <= '0;
         flushes_q  <= '0;
         mispred_q  <= '0;
         cpi_q      <= '0;
         rd_data_q  <= '0;
         dividend_q <= '0;
         quot_q     <= '0;
         rem_q      <= '0;
         bitcnt_q   <= '0;
      end else begin
         state_q    <= state_d;
         cycles_q   <= cycles_d;
         retired_q  <= retired_d;
         stalls_q   <= stalls_d;
         flushes_q  <= flushes_d;
         mispred_q  <= mispred_d;
         cpi_q      <= cpi_d;
         rd_data_q  <= rd_data_d;
         dividend_q <= dividend_d;
         quot_q     <= quot_d;
         rem_q      <= rem_d;
         bitcnt_q   <= bitcnt_d;
      end
   end

   assign rd_data_o   = rd_data_q;
   assign busy_o      = (state_q == S_RUN) || (state_q == S_DIV);
   assign done_o      = (state_q == S_DONE);
   assign cpi_valid_o = (state_q == S_DONE);
   assign cpi_o       = cpi_q;

endmodule

// File: tb/tb_perf_monitor.sv
// Directed bench for perf_monitor: a default-width instance and a narrow
// (CNT_W=8, FRAC_W=4) instance share one stimulus stream.
module tb_perf_monitor;

   logic        clock = 1'b0;
   logic        resetN;
   logic        start, stop, wbValid, stall, flush, mispred;
   logic [31:0] wbData;
   logic [2:0]  sel;

   logic [31:0] rdData, cpi;
   logic        busy, done, cpiValid;
   logic [7:0]  sRdData, sCpi;
   logic        sBusy, sDone, sCpiValid;

   int assertCount = 0;
   int failCount   = 0;

   logic [31:0] bigVal, smallVal;
   int          divCycles;

   always #5 clock = ~clock;

   perf_monitor dut (
      .clk_i(clock), .reset_ni(resetN), .start_i(start), .stop_i(stop),
      .wb_valid_i(wbValid), .wb_data_i(wbData), .stall_i(stall),
      .flush_i(flush), .mispredict_i(mispred), .sel_i(sel),
      .rd_data_o(rdData), .busy_o(busy), .done_o(done), .cpi_o(cpi),
      .cpi_valid_o(cpiValid)
   );

   perf_monitor #(.CNT_W(8), .FRAC_W(4)) dutSmall (
      .clk_i(clock), .reset_ni(resetN), .start_i(start), .stop_i(stop),
      .wb_valid_i(wbValid), .wb_data_i(wbData), .stall_i(stall),
      .flush_i(flush), .mispredict_i(mispred), .sel_i(sel),
      .rd_data_o(sRdData), .busy_o(sBusy), .done_o(sDone), .cpi_o(sCpi),
      .cpi_valid_o(sCpiValid)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Called at a negedge; drives one cycle of inputs and returns at the next negedge.
   task automatic applyStimulus(input logic st, input logic sp, input logic wv,
                                input logic [31:0] wd, input logic sl,
                                input logic fl, input logic mp);
      start = st; stop = sp; wbValid = wv; wbData = wd;
      stall = sl; flush = fl; mispred = mp;
      @(negedge clock);
      start = 0; stop = 0; wbValid = 0; wbData = 0;
      stall = 0; flush = 0; mispred = 0;
   endtask

   task automatic readSel(input logic [2:0] s, output logic [31:0] b,
                          output logic [31:0] sm);
      sel = s;
      @(negedge clock);
      b  = rdData;
      sm = {24'd0, sRdData};
   endtask

   task automatic waitDiv(input bit useSmall, output int n);
      n = 0;
      while ((useSmall ? sBusy : busy) && n < 200) begin
         n++;
         @(negedge clock);
      end
   endtask

   initial begin
      resetN = 0; start = 0; stop = 0; wbValid = 0; wbData = 0;
      stall = 0; flush = 0; mispred = 0; sel = 0;
      #2;
      checkOutput("reset busy", {31'd0, busy}, 32'd0);
      checkOutput("reset done", {31'd0, done}, 32'd0);
      checkOutput("reset cpiValid", {31'd0, cpiValid}, 32'd0);
      checkOutput("reset cpi", cpi, 32'd0);
      checkOutput("reset rdData", rdData, 32'd0);
      @(negedge clock);
      resetN = 1;
      @(negedge clock);
      readSel(3'd5, bigVal, smallVal);
      checkOutput("cpi before first run", bigVal, 32'd0);

      // Basic CPI: 10 cycles, 5 retires, stop on the 10th
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      checkOutput("run busy", {31'd0, busy}, 32'd1);
      for (int i = 0; i < 10; i++)
         applyStimulus(0, i == 9, (i % 2) == 0, 32'd0, 0, 0, 0);
      waitDiv(0, divCycles);
      checkOutput("basic div cycles", divCycles, 32'd40);
      checkOutput("basic done", {31'd0, done}, 32'd1);
      checkOutput("basic cpiValid", {31'd0, cpiValid}, 32'd1);
      checkOutput("basic cpi", cpi, 32'h200);
      readSel(3'd0, bigVal, smallVal);
      checkOutput("basic cycles", bigVal, 32'd10);
      readSel(3'd1, bigVal, smallVal);
      checkOutput("basic retired", bigVal, 32'd5);
      readSel(3'd5, bigVal, smallVal);
      checkOutput("basic rd cpi", bigVal, 32'h200);

      // Fractional CPI, end by writeback of END_VALUE; 0x90 without valid is ignored
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      checkOutput("restart clears valid", {31'd0, cpiValid}, 32'd0);
      for (int i = 0; i < 7; i++)
         applyStimulus(0, 0, (i == 1) || (i == 3) || (i == 6),
                       (i == 4 || i == 6) ? 32'h90 : 32'd5, 0, 0, 0);
      waitDiv(0, divCycles);
      checkOutput("frac div cycles", divCycles, 32'd40);
      checkOutput("frac cpi", cpi, 32'h255);
      readSel(3'd0, bigVal, smallVal);
      checkOutput("frac cycles", bigVal, 32'd7);
      readSel(3'd1, bigVal, smallVal);
      checkOutput("frac retired", bigVal, 32'd3);

      // Zero retired
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++)
         applyStimulus(0, i == 3, 0, 32'd0, 0, 0, 0);
      waitDiv(0, divCycles);
      checkOutput("zero div cycles", divCycles, 32'd1);
      checkOutput("zero cpi", cpi, 32'hFFFF_FFFF);
      checkOutput("zero cpiValid", {31'd0, cpiValid}, 32'd1);
      checkOutput("zero small cpi", {24'd0, sCpi}, 32'hFF);

      // Saturation on the narrow instance
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 300; i++)
         applyStimulus(0, i == 299, i == 0, 32'd0, 1, 0, 0);
      waitDiv(1, divCycles);
      checkOutput("sat small div cycles", divCycles, 32'd12);
      checkOutput("sat small done", {31'd0, sDone}, 32'd1);
      checkOutput("sat small cpi", {24'd0, sCpi}, 32'hFF);
      waitDiv(0, divCycles);
      checkOutput("sat big done", {31'd0, done}, 32'd1);
      checkOutput("sat big cpi", cpi, 32'h12C00);
      readSel(3'd0, bigVal, smallVal);
      checkOutput("sat small cycles", smallVal, 32'hFF);
      readSel(3'd2, bigVal, smallVal);
      checkOutput("sat small stalls", smallVal, 32'hFF);
      checkOutput("sat big stalls", bigVal, 32'd300);
      readSel(3'd1, bigVal, smallVal);
      checkOutput("sat small retired", smallVal, 32'd1);

      // Event accounting with live readout during RUN
      sel = 3'd0;
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(0, i == 7, (8'b0100_1000 >> i) & 1, 32'd0,
                       (8'b1001_0011 >> i) & 1, (8'b0010_1010 >> i) & 1,
                       (8'b0100_0100 >> i) & 1);
         if (i == 4) checkOutput("live cycles", rdData, 32'd4);
      end
      waitDiv(0, divCycles);
      checkOutput("event cpi", cpi, 32'h400);
      readSel(3'd0, bigVal, smallVal);
      checkOutput("event cycles", bigVal, 32'd8);
      readSel(3'd1, bigVal, smallVal);
      checkOutput("event retired", bigVal, 32'd2);
      readSel(3'd2, bigVal, smallVal);
      checkOutput("event stalls", bigVal, 32'd4);
      readSel(3'd3, bigVal, smallVal);
      checkOutput("event flushes", bigVal, 32'd3);
      readSel(3'd4, bigVal, smallVal);
      checkOutput("event mispredicts", bigVal, 32'd2);
      readSel(3'd6, bigVal, smallVal);
      checkOutput("event sel6", bigVal, 32'd0);
      readSel(3'd7, bigVal, smallVal);
      checkOutput("event sel7", bigVal, 32'd0);

      // Restart: start coincident with stop keeps RUN and clears counters
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++)
         applyStimulus(0, 0, 1, 32'd0, 0, 0, 0);
      applyStimulus(1, 1, 1, 32'd0, 0, 0, 0);
      checkOutput("restart busy", {31'd0, busy}, 32'd1);
      checkOutput("restart done", {31'd0, done}, 32'd0);
      for (int i = 0; i < 2; i++)
         applyStimulus(0, i == 1, 1, 32'd0, 0, 0, 0);
      waitDiv(0, divCycles);
      checkOutput("restart div cycles", divCycles, 32'd40);
      checkOutput("restart cpi", cpi, 32'h100);
      readSel(3'd0, bigVal, smallVal);
      checkOutput("restart cycles", bigVal, 32'd2);

      // Asynchronous reset during DIV
      sel = 3'd1;
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++)
         applyStimulus(0, i == 2, 1, 32'd0, 0, 0, 0);
      repeat (5) @(negedge clock);
      checkOutput("pre-reset busy", {31'd0, busy}, 32'd1);
      checkOutput("pre-reset rdData", rdData, 32'd3);
      #2 resetN = 0;
      #1;
      checkOutput("async busy", {31'd0, busy}, 32'd0);
      checkOutput("async done", {31'd0, done}, 32'd0);
      checkOutput("async cpiValid", {31'd0, cpiValid}, 32'd0);
      checkOutput("async cpi", cpi, 32'd0);
      checkOutput("async rdData", rdData, 32'd0);
      @(negedge clock);
      resetN = 1;
      readSel(3'd0, bigVal, smallVal);
      checkOutput("post-reset cycles", bigVal, 32'd0);
      checkOutput("post-reset idle", {31'd0, busy}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
